// File: rtl/serial_word_tx_pkg.sv
// serial_word_tx shared types
// FSM state encoding and counter sizing helper
package serial_word_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_GAP   = 2'b10
  } state_e;

  localparam int GAP_CW = 4;

  function automatic int cnt_w(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_word_tx_hold_buf.sv
// word_hold_buf: single-entry word register
// load fills it, take empties it, ready = !full
module word_hold_buf
  import serial_word_tx_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             take_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic             full_o,
  output logic             ready_o
);

  logic             full_q;
  logic [WIDTH-1:0] data_q;

  // capture a word on load, release the slot on take
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (load_i) begin
      full_q <= 1'b1;
      data_q <= d_i;
    end else if (take_i) begin
      full_q <= 1'b0;
    end
  end

  assign q_o     = data_q;
  assign full_o  = full_q;
  assign ready_o = !full_q;

endmodule

// File: rtl/serial_word_tx.sv
// serial_word_tx: parallel word in, one bit per clock out
// zero on the line when idle, optional idle gap per word
module serial_word_tx
  import serial_word_tx_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int GAP       = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [GAP_CW-1:0] GAP_LAST =
    GAP_CW'((GAP > 0) ? GAP - 1 : 0);

  state_e state_q, state_d;

  logic [WIDTH-1:0]  sh_q, sh_d, sh_next;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [GAP_CW-1:0] gap_cnt_q, gap_cnt_d;

  logic             hold_load, hold_take;
  logic             hold_full, hold_ready;
  logic [WIDTH-1:0] hold_q;
  logic             xfer, last_bit, gap_last;

  word_hold_buf #(.WIDTH(WIDTH)) u_hold (
    .clk     (clk),
    .rst_ni  (rst),
    .load_i  (hold_load),
    .take_i  (hold_take),
    .d_i     (din),
    .q_o     (hold_q),
    .full_o  (hold_full),
    .ready_o (hold_ready)
  );

  assign din_ready = hold_ready;
  assign xfer      = din_valid && hold_ready;
  assign last_bit  = (bit_cnt_q == LAST_BIT);
  assign gap_last  = (gap_cnt_q == GAP_LAST);
  assign sh_next   = MSB_FIRST ? {sh_q[WIDTH-2:0], 1'b0}
                               : {1'b0, sh_q[WIDTH-1:1]};

  // state, shifter and counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      sh_q      <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  // next state: where each accepted word goes and when
  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    hold_load = 1'b0;
    hold_take = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          sh_d      = din;
          bit_cnt_d = '0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sh_d      = sh_next;
        bit_cnt_d = bit_cnt_q + 1'b1;
        hold_load = xfer;
        if (last_bit) begin
          bit_cnt_d = '0;
          if (GAP != 0) begin
            gap_cnt_d = '0;
            state_d   = ST_GAP;
          end else if (hold_full) begin
            sh_d      = hold_q;
            hold_take = 1'b1;
          end else if (xfer) begin
            sh_d      = din;
            hold_load = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        gap_cnt_d = gap_cnt_q + 1'b1;
        hold_load = xfer;
        if (gap_last) begin
          gap_cnt_d = '0;
          bit_cnt_d = '0;
          if (hold_full) begin
            sh_d      = hold_q;
            hold_take = 1'b1;
            state_d   = ST_SHIFT;
          end else if (xfer) begin
            sh_d      = din;
            hold_load = 1'b0;
            state_d   = ST_SHIFT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ser_valid = (state_q == ST_SHIFT);
  assign ser_out   = ser_valid &&
                     (MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0]);
  assign word_done = ser_valid && last_bit;
  assign busy      = (state_q != ST_IDLE) || hold_full;

endmodule

// File: tb/tb_serial_word_tx.sv
// tb_serial_word_tx: three configurations of serial_word_tx
// scoreboard of expected bits per accepted word
module tb_serial_word_tx;

  logic       clk;
  logic       rst;
  logic [7:0] din [3];
  logic [2:0] dv;
  wire  [2:0] rdy, so, sv, wdn, bz;

  int chk;
  int pass;
  logic [7:0] wl[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 0: MSB first, no gap; 1: MSB first, gap 2; 2: LSB first
  for (genvar i = 0; i < 3; i++) begin : g_dut
    serial_word_tx #(
      .WIDTH    (8),
      .MSB_FIRST(i == 2 ? 1'b0 : 1'b1),
      .GAP      (i == 1 ? 2 : 0)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .din      (din[i]),
      .din_valid(dv[i]),
      .din_ready(rdy[i]),
      .ser_out  (so[i]),
      .ser_valid(sv[i]),
      .word_done(wdn[i]),
      .busy     (bz[i])
    );
  end

  task automatic test_reset();
    rst = 1'b0;
    dv  = '0;
    for (int k = 0; k < 3; k++) din[k] = 8'h00;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 2) rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
        chk++;
        if ({so[k], sv[k], wdn[k], bz[k], rdy[k]} !== 5'b00001)
          $display("FAIL reset d%0d c%0d got %b exp 00001",
                   k, c, {so[k], sv[k], wdn[k], bz[k], rdy[k]});
        else pass++;
      end
    end
  endtask

  // sends wl on dut k; lazy presents each next word only
  // during the previous word's last bit
  task automatic stream(input int k, input int gap,
                        input bit lazy);
    bit eb[$], el[$], ef[$];
    bit msb, acc, in_gap, exp_v, b, l, f, mrdy;
    int n, idx, cyc, tail, idle_need, notst;
    logic [7:0] w;
    msb = (k != 2);
    n = wl.size();
    idx = 0; cyc = 0; tail = 0;
    idle_need = 0; notst = 0; mrdy = 1'b1;
    @(negedge clk);
    din[k] = wl[0];
    dv[k]  = 1'b1;
    while (cyc < 200 && tail < 3) begin
      acc = dv[k] && mrdy;
      if (acc) begin
        w = din[k];
        for (int j = 0; j < 8; j++) begin
          eb.push_back(msb ? w[7-j] : w[j]);
          el.push_back(j == 7);
          ef.push_back(j == 0);
        end
        notst++;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (acc) begin
        idx++;
        if (lazy || idx >= n) dv[k] = 1'b0;
        else din[k] = wl[idx];
      end
      in_gap = (idle_need > 0);
      exp_v  = in_gap ? 1'b0 : (eb.size() > 0);
      chk++;
      if (sv[k] !== exp_v)
        $display("FAIL valid d%0d cyc%0d got %b exp %b",
                 k, cyc, sv[k], exp_v);
      else pass++;
      if (exp_v) begin
        b = eb.pop_front();
        l = el.pop_front();
        f = ef.pop_front();
        if (f) notst--;
        chk++;
        if (so[k] !== b)
          $display("FAIL bit d%0d cyc%0d got %b exp %b",
                   k, cyc, so[k], b);
        else pass++;
        chk++;
        if (wdn[k] !== l)
          $display("FAIL done d%0d cyc%0d got %b exp %b",
                   k, cyc, wdn[k], l);
        else pass++;
        if (l) idle_need = gap;
        if (l && lazy && idx < n) begin
          din[k] = wl[idx];
          dv[k]  = 1'b1;
        end
      end else begin
        chk++;
        if ({so[k], wdn[k]} !== 2'b00)
          $display("FAIL idle_line d%0d cyc%0d got %b exp 00",
                   k, cyc, {so[k], wdn[k]});
        else pass++;
        if (in_gap) idle_need--;
      end
      chk++;
      if (bz[k] !== (exp_v || in_gap))
        $display("FAIL busy d%0d cyc%0d got %b exp %b",
                 k, cyc, bz[k], exp_v || in_gap);
      else pass++;
      mrdy = (notst == 0);
      chk++;
      if (rdy[k] !== mrdy)
        $display("FAIL ready d%0d cyc%0d got %b exp %b",
                 k, cyc, rdy[k], mrdy);
      else pass++;
      if (idx >= n && eb.size() == 0 && idle_need == 0)
        tail++;
    end
    dv[k] = 1'b0;
    chk++;
    if (cyc >= 200)
      $display("FAIL timeout d%0d got %0d cycles exp <200",
               k, cyc);
    else pass++;
  endtask

  task automatic test_single();
    wl = {8'hA5};
    stream(0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    wl = {8'hFF, 8'h00};
    stream(0, 0, 1'b0);
    wl.delete();
    for (int i = 0; i < 4; i++)
      wl.push_back(8'($urandom_range(0, 255)));
    stream(0, 0, 1'b0);
  endtask

  task automatic test_gap();
    wl = {8'hC3, 8'h3C};
    stream(1, 2, 1'b0);
    wl = {8'h81, 8'h7E};
    stream(1, 2, 1'b1);
  endtask

  task automatic test_lsb_same_edge();
    wl = {8'h01, 8'h80, 8'h5A};
    stream(2, 0, 1'b1);
    wl = {8'hB2, 8'h4D};
    stream(0, 0, 1'b1);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    din[0] = 8'hF0;
    dv[0]  = 1'b1;
    @(negedge clk);
    din[0] = 8'h0F;
    @(negedge clk);
    dv[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk++;
    if ({so[0], sv[0], bz[0], rdy[0]} !== 4'b1110)
      $display("FAIL pre_reset got %b exp 1110",
               {so[0], sv[0], bz[0], rdy[0]});
    else pass++;
    #2 rst = 1'b0;
    #1;
    chk++;
    if ({so[0], sv[0], wdn[0], bz[0], rdy[0]} !== 5'b00001)
      $display("FAIL async_reset got %b exp 00001",
               {so[0], sv[0], wdn[0], bz[0], rdy[0]});
    else pass++;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk++;
      if ({so[0], sv[0], wdn[0], bz[0], rdy[0]} !== 5'b00001)
        $display("FAIL post_reset c%0d got %b exp 00001",
                 c, {so[0], sv[0], wdn[0], bz[0], rdy[0]});
      else pass++;
    end
  endtask

  initial begin
    chk  = 0;
    pass = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_gap();
    test_lsb_same_edge();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule
